// File: rtl/grant_burst_mover.sv
// grant_burst_mover: moves a granted requester's burst onto a shared valid/ready stream.
// Optional GBM_ABORT_EN: a grant dropped mid-burst ends the burst early.
module grant_burst_mover #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              gnt_0,
  input  logic              gnt_1,
  input  logic [LEN_W-1:0]  len_0,
  input  logic [LEN_W-1:0]  len_1,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  output logic              rd_0,
  output logic              rd_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done_0,
  output logic              done_1,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, XFER0, XFER1, RELEASE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic xfer, sel1, fire, stop;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // A zero-length grant still spends one cycle in XFERx so done_x lands a cycle after the grant.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xfer      = state_q == XFER0 || state_q == XFER1;
    sel1      = state_q == XFER1;
    out_valid = xfer && cnt_q != '0;
    out_data  = !xfer ? '0 : sel1 ? data_1 : data_0;
    out_last  = out_valid && cnt_q == LEN_W'(1);
    fire      = out_valid && out_ready;
`ifdef GBM_ABORT_EN
    stop      = xfer && (cnt_q == '0 || (fire && cnt_q == LEN_W'(1)) || !(sel1 ? gnt_1 : gnt_0));
`else
    stop      = xfer && (cnt_q == '0 || (fire && cnt_q == LEN_W'(1)));
`endif
    rd_0      = fire && !sel1;
    rd_1      = fire && sel1;
    done_0    = stop && !sel1;
    done_1    = stop && sel1;
    busy      = state_q != IDLE;
    if (state_q == IDLE) begin
      if (gnt_0) begin
        cnt_d   = len_0;
        state_d = XFER0;
      end else if (gnt_1) begin
        cnt_d   = len_1;
        state_d = XFER1;
      end
    end else if (xfer) begin
      cnt_d   = fire ? cnt_q - LEN_W'(1) : cnt_q;
      state_d = stop ? RELEASE : state_q;
    end else if (!gnt_0 && !gnt_1) begin
      state_d = IDLE;
    end
  end
endmodule

// File: tb/tb_grant_burst_mover.sv
// tb_grant_burst_mover: randomized and directed bursts checked each cycle against a
// burst-level model (owner, beats remaining) of the mover.
module tb_grant_burst_mover;
  logic       clock = 0;
  logic       reset_n = 0;
  logic       gnt_0 = 0, gnt_1 = 0, out_ready = 0;
  logic [3:0] len_0 = 0, len_1 = 0;
  logic [7:0] data_0 = 0, data_1 = 0, out_data;
  logic       rd_0, rd_1, out_valid, out_last, done_0, done_1, busy;
  int total = 0, bad = 0, mode = 0;
  int n_rd0 = 0, n_rd1 = 0, n_d0 = 0, n_d1 = 0, n_v = 0, n_l = 0;
  int s_rd0, s_rd1, s_d0, s_d1, s_v, s_l;
  int ph = 0, src = 0, rem = 0;
  typedef struct packed {
    logic v, l, r0, r1, d0, d1, b;
    logic [7:0] dat;
  } exp_t;

  grant_burst_mover dut (
    .clock(clock), .reset_n(reset_n), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .len_0(len_0), .len_1(len_1), .data_0(data_0), .data_1(data_1),
    .rd_0(rd_0), .rd_1(rd_1), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done_0(done_0), .done_1(done_1),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // ph: 0 waiting for a grant, 1 moving a burst from src with rem beats left, 2 waiting for grants to fall
  function automatic exp_t calc();
    exp_t e = '0;
    logic acc, fin;
    if (!reset_n) return e;
    e.b = ph != 0;
    if (ph == 1) begin
      e.v   = rem > 0;
      e.l   = rem == 1;
      e.dat = src == 1 ? data_1 : data_0;
      acc   = e.v && out_ready;
      fin   = rem == 0 || (acc && rem == 1);
`ifdef GBM_ABORT_EN
      fin   = fin || !(src == 1 ? gnt_1 : gnt_0);
`endif
      e.r0  = acc && src == 0;
      e.r1  = acc && src == 1;
      e.d0  = fin && src == 0;
      e.d1  = fin && src == 1;
    end
    return e;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      ph <= 0;
      rem <= 0;
    end else begin
      e = calc();
      if (ph == 0) begin
        if (gnt_0 || gnt_1) begin
          ph  <= 1;
          src <= gnt_0 ? 0 : 1;
          rem <= gnt_0 ? int'(len_0) : int'(len_1);
        end
      end else if (ph == 1) begin
        if (e.d0 || e.d1) ph <= 2;
        else if (e.r0 || e.r1) rem <= rem - 1;
      end else if (!gnt_0 && !gnt_1) ph <= 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    e = calc();
    chk("out_valid", int'(out_valid), int'(e.v));
    chk("out_last", int'(out_last), int'(e.l));
    chk("out_data", int'(out_data), int'(e.dat));
    chk("rd_0", int'(rd_0), int'(e.r0));
    chk("rd_1", int'(rd_1), int'(e.r1));
    chk("done_0", int'(done_0), int'(e.d0));
    chk("done_1", int'(done_1), int'(e.d1));
    chk("busy", int'(busy), int'(e.b));
    n_rd0 <= n_rd0 + int'(rd_0);
    n_rd1 <= n_rd1 + int'(rd_1);
    n_d0  <= n_d0 + int'(done_0);
    n_d1  <= n_d1 + int'(done_1);
    n_v   <= n_v + int'(out_valid && out_ready);
    n_l   <= n_l + int'(out_last && out_ready);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      data_0 = 8'($urandom);
      data_1 = 8'($urandom);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : ($urandom_range(0, 9) < 7);
    end
  endtask

  task automatic snap();
    s_rd0 = n_rd0; s_rd1 = n_rd1; s_d0 = n_d0; s_d1 = n_d1; s_v = n_v; s_l = n_l;
  endtask

  initial begin
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    step(2);
    reset_n = 1;
    step(2);
    // 3-beat burst from source 0, sink always ready
    snap();
    gnt_0 = 1; len_0 = 3;
    step(10);
    chk("t1_rd0", n_rd0 - s_rd0, 3);
    chk("t1_done0", n_d0 - s_d0, 1);
    chk("t1_last", n_l - s_l, 1);
    chk("t1_release_busy", int'(busy), 1);
    gnt_0 = 0;
    step(2);
    chk("t1_idle_busy", int'(busy), 0);
    // 4-beat burst from source 1 with a toggling sink
    snap();
    mode = 1; gnt_1 = 1; len_1 = 4;
    step(16);
    chk("t2_rd1", n_rd1 - s_rd1, 4);
    chk("t2_done1", n_d1 - s_d1, 1);
    chk("t2_rd0", n_rd0 - s_rd0, 0);
    gnt_1 = 0; mode = 0;
    step(2);
    // simultaneous grants: source 0 wins
    snap();
    gnt_0 = 1; gnt_1 = 1; len_0 = 2; len_1 = 5;
    step(8);
    chk("t3_rd0", n_rd0 - s_rd0, 2);
    chk("t3_rd1", n_rd1 - s_rd1, 0);
    chk("t3_done0", n_d0 - s_d0, 1);
    gnt_0 = 0; gnt_1 = 0;
    step(2);
    // zero-length burst
    snap();
    gnt_0 = 1; len_0 = 0;
    step(1);
    chk("t4_done_next", int'(done_0), 1);
    step(4);
    chk("t4_valid", n_v - s_v, 0);
    chk("t4_rd0", n_rd0 - s_rd0, 0);
    chk("t4_done0", n_d0 - s_d0, 1);
    gnt_0 = 0;
    step(2);
    // reset in the middle of a 5-beat burst
    snap();
    gnt_0 = 1; len_0 = 5;
    for (int i = 0; i < 30 && n_rd0 - s_rd0 < 2; i++) step(1);
    chk("t5_pre_rd0", n_rd0 - s_rd0, 2);
    reset_n = 0;
    #1;
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_rd0", int'(rd_0), 0);
    chk("t5_done0", int'(done_0), 0);
    gnt_0 = 0;
    step(2);
    reset_n = 1;
    step(2);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_done_total", n_d0 - s_d0, 0);
`ifdef GBM_ABORT_EN
    // grant withdrawn after two beats
    snap();
    gnt_0 = 1; len_0 = 6;
    for (int i = 0; i < 30 && n_rd0 - s_rd0 < 2; i++) step(1);
    gnt_0 = 0;
    step(4);
    chk("t6_done0", n_d0 - s_d0, 1);
    chk("t6_pops_ok", int'(n_rd0 - s_rd0 >= 2 && n_rd0 - s_rd0 <= 3), 1);
    chk("t6_idle_busy", int'(busy), 0);
`endif
    // randomized grants, lengths and sink backpressure
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) gnt_0 = ~gnt_0;
      if ($urandom_range(0, 7) == 0) gnt_1 = ~gnt_1;
      len_0 = 4'($urandom);
      len_1 = 4'($urandom);
      step(1);
    end
    gnt_0 = 0; gnt_1 = 0;
    step(40);
    chk("final_idle", int'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
